// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types, constants and helpers for the stream multiplexer.
package stream_mux_pkg;
   typedef enum logic {MODE_SELECT = 1'b0, MODE_RR = 1'b1} mode_e;
   localparam int STAT_W = 16;
   function automatic int ch_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/stream_mux_if.sv
// stream_mux_if: producer-side and consumer-side handshake bundle of the stream multiplexer.
interface stream_mux_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 4
);
   localparam int CH_W = stream_mux_pkg::ch_w(N_CH);
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CH_W-1:0]       out_ch;
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr_i, wrapping mod N_CH.
module rr_arbiter import stream_mux_pkg::*; #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         req_i,
   input  logic [ch_w(N_CH)-1:0]   ptr_i,
   output logic [ch_w(N_CH)-1:0]   grant_o,
   output logic                    grant_valid_o
);
   localparam int CH_W = ch_w(N_CH);
   logic [CH_W-1:0] idx;
   always_comb begin
      grant_o = '0;
      grant_valid_o = 1'b0;
      idx = ptr_i;
      for (int k = 0; k < N_CH; k++) begin
         idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
         if (req_i[idx] && !grant_valid_o) begin
            grant_o = idx;
            grant_valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel registered stream mux, SELECT or round-robin grant, one output stage.
// Define STREAM_MUX_STATS_EN to add per-channel saturating accepted-beat counters (stat_cnt).
module stream_mux import stream_mux_pkg::*; #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 4,
   parameter int MODE  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [ch_w(N_CH)-1:0]     sel,
`ifdef STREAM_MUX_STATS_EN
   output logic [N_CH*STAT_W-1:0]    stat_cnt,
`endif
   stream_mux_if.slave               bus
);
   localparam int CH_W = ch_w(N_CH);
   logic [CH_W-1:0]  gnt, out_ch_q, out_ch_d;
   logic             gnt_vld, load, xfer, out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   assign load = en && (!out_valid_q || bus.out_ready);
   assign bus.in_ready = (load && gnt_vld) ? N_CH'(1) << gnt : '0;
   assign xfer = |(bus.in_valid & bus.in_ready);
   if (MODE == int'(MODE_RR)) begin : g_rr
      logic [CH_W-1:0] rr_ptr_q;
      logic            unused_sel;
      assign unused_sel = ^sel;
      rr_arbiter #(.N_CH(N_CH)) u_arb (
         .req_i         (bus.in_valid),
         .ptr_i         (rr_ptr_q),
         .grant_o       (gnt),
         .grant_valid_o (gnt_vld)
      );
      // Pointer starts at the last channel so channel 0 wins the first arbitration.
      always_ff @(posedge clk) begin
         if (rst) rr_ptr_q <= CH_W'(N_CH - 1);
         else if (xfer) rr_ptr_q <= gnt;
      end
   end else begin : g_sel
      assign gnt = sel;
      assign gnt_vld = int'(sel) < N_CH;
   end
   always_comb begin
      out_valid_d = xfer || (out_valid_q && !bus.out_ready);
      out_data_d = xfer ? bus.in_data[int'(gnt)*WIDTH +: WIDTH] : out_data_q;
      out_ch_d = xfer ? gnt : out_ch_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_ch_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_ch_q <= out_ch_d;
      end
   end
   // An empty output register reads as all-zero data and channel.
   assign bus.out_valid = out_valid_q;
   assign bus.out_data = out_valid_q ? out_data_q : '0;
   assign bus.out_ch = out_valid_q ? out_ch_q : '0;
`ifdef STREAM_MUX_STATS_EN
   for (genvar i = 0; i < N_CH; i++) begin : g_stat
      logic [STAT_W-1:0] cnt_q;
      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else if (bus.in_valid[i] && bus.in_ready[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      assign stat_cnt[i*STAT_W +: STAT_W] = cnt_q;
   end
`endif
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: three muxes (SELECT/4ch, RR/4ch, SELECT/3ch) share stimulus, checked against a spec model.
module tb_stream_mux;
   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, out_ready = 1'b0;
   logic [1:0]  sel = '0;
   logic [15:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   int          n_chk = 0, n_err = 0;
   bit          go = 1'b0;
   always #5 clk = ~clk;
   stream_mux_if #(.N_CH(4), .WIDTH(4)) if0 ();
   stream_mux_if #(.N_CH(4), .WIDTH(4)) if1 ();
   stream_mux_if #(.N_CH(3), .WIDTH(4)) if2 ();
   assign if0.in_data = in_data;
   assign if0.in_valid = in_valid;
   assign if0.out_ready = out_ready;
   assign if1.in_data = in_data;
   assign if1.in_valid = in_valid;
   assign if1.out_ready = out_ready;
   assign if2.in_data = in_data[11:0];
   assign if2.in_valid = in_valid[2:0];
   assign if2.out_ready = out_ready;
`ifdef STREAM_MUX_STATS_EN
   logic [63:0] st0, st1;
   logic [47:0] st2;
`endif
   stream_mux #(.N_CH(4), .WIDTH(4), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .sel(sel),
`ifdef STREAM_MUX_STATS_EN
      .stat_cnt(st0),
`endif
      .bus(if0)
   );
   stream_mux #(.N_CH(4), .WIDTH(4), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .sel(sel),
`ifdef STREAM_MUX_STATS_EN
      .stat_cnt(st1),
`endif
      .bus(if1)
   );
   stream_mux #(.N_CH(3), .WIDTH(4), .MODE(0)) u2 (
      .clk(clk), .rst(rst), .en(en), .sel(sel),
`ifdef STREAM_MUX_STATS_EN
      .stat_cnt(st2),
`endif
      .bus(if2)
   );
   logic [3:0] a_rdy [3];
   logic [3:0] a_dat [3];
   logic       a_vld [3];
   logic [1:0] a_ch  [3];
   assign a_rdy[0] = if0.in_ready;
   assign a_rdy[1] = if1.in_ready;
   assign a_rdy[2] = {1'b0, if2.in_ready};
   assign a_dat[0] = if0.out_data;
   assign a_dat[1] = if1.out_data;
   assign a_dat[2] = if2.out_data;
   assign a_vld[0] = if0.out_valid;
   assign a_vld[1] = if1.out_valid;
   assign a_vld[2] = if2.out_valid;
   assign a_ch[0] = if0.out_ch;
   assign a_ch[1] = if1.out_ch;
   assign a_ch[2] = if2.out_ch;
   // Model state: what the output register holds, and the last channel granted in RR mode.
   int nch [3] = '{4, 4, 3};
   int mode [3] = '{0, 1, 0};
   bit m_vld [3];
   int m_dat [3], m_ch [3], m_last [3];
   function automatic int m_grant(input int d);
      if (mode[d] == 0) return (int'(sel) < nch[d]) ? int'(sel) : -1;
      for (int k = 1; k <= nch[d]; k++)
         if (in_valid[(m_last[d] + k) % nch[d]]) return (m_last[d] + k) % nch[d];
      return -1;
   endfunction
   function automatic int m_rdy(input int d);
      int g;
      g = m_grant(d);
      return (en && (!m_vld[d] || out_ready) && g >= 0) ? (1 << g) : 0;
   endfunction
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   always @(posedge clk) begin : mdl
      int g;
      bit x;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_vld[d] = 1'b0;
            m_dat[d] = 0;
            m_ch[d] = 0;
            m_last[d] = nch[d] - 1;
         end else begin
            g = m_grant(d);
            x = m_rdy(d) != 0 && in_valid[g];
            if (x) begin
               m_vld[d] = 1'b1;
               m_dat[d] = int'(in_data[g*4 +: 4]);
               m_ch[d] = g;
               if (mode[d] == 1) m_last[d] = g;
            end else if (out_ready) m_vld[d] = 1'b0;
         end
      end
   end
   always @(negedge clk) begin
      if (go) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_ready[%0d]", d), int'(a_rdy[d]), m_rdy(d));
            chk($sformatf("out_valid[%0d]", d), int'(a_vld[d]), int'(m_vld[d]));
            chk($sformatf("out_data[%0d]", d), int'(a_dat[d]), m_vld[d] ? m_dat[d] : 0);
            chk($sformatf("out_ch[%0d]", d), int'(a_ch[d]), m_vld[d] ? m_ch[d] : 0);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic neg();
      @(negedge clk);
   endtask
   initial begin
      int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      tick();
      tick();
      rst = 1'b0;
      go = 1'b1;
      neg();
      chk("reset_valid", int'(if0.out_valid), 0);
      chk("reset_data", int'(if0.out_data), 0);
      tick();
      en = 1'b1; sel = 2'd2; in_valid = 4'b0100; in_data = 16'h0A00; out_ready = 1'b1;
      neg();
      chk("sel_ready", int'(if0.in_ready), 4'b0100);
      tick();
      in_valid = '0;
      neg();
      chk("sel_valid", int'(if0.out_valid), 1);
      chk("sel_data", int'(if0.out_data), 4'hA);
      chk("sel_ch", int'(if0.out_ch), 2);
      tick();
      en = 1'b0; in_valid = 4'hF; in_data = 16'h4321;
      neg();
      chk("dis_ready", int'(if0.in_ready), 0);
      chk("dis_valid", int'(if0.out_valid), 0);
      chk("dis_data", int'(if0.out_data), 0);
      tick();
      neg();
      chk("dis_ready2", int'(if1.in_ready), 0);
      tick();
      en = 1'b1; sel = 2'd1; in_valid = 4'b0010; in_data = 16'h0030; out_ready = 1'b0;
      neg();
      chk("bp_accept", int'(if0.in_ready), 4'b0010);
      for (int i = 0; i < 3; i++) begin
         tick();
         in_data = 16'h0050;
         neg();
         chk("bp_hold_data", int'(if0.out_data), 4'h3);
         chk("bp_hold_ready", int'(if0.in_ready), 0);
      end
      tick();
      out_ready = 1'b1;
      neg();
      chk("bp_release_ready", int'(if0.in_ready), 4'b0010);
      tick();
      in_data = 16'h0070;
      neg();
      chk("tput_beat1", int'(if0.out_data), 4'h5);
      tick();
      out_ready = 1'b0;
      neg();
      chk("tput_beat2", int'(if0.out_data), 4'h7);
      tick();
      rst = 1'b1;
      neg();
      chk("pre_rst_valid", int'(if0.out_valid), 1);
      tick();
      rst = 1'b0; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
      neg();
      chk("mid_rst_valid", int'(if0.out_valid), 0);
      chk("mid_rst_data", int'(if0.out_data), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         neg();
         chk($sformatf("rr_ch%0d", i), int'(if1.out_ch), exp_ch[i]);
         chk($sformatf("rr_data%0d", i), int'(if1.out_data), 4'hA + exp_ch[i]);
      end
      tick();
      in_valid = 4'b0010;
      tick();
      in_valid = 4'b1010;
      neg();
      chk("rr_ch1", int'(if1.out_ch), 1);
      tick();
      neg();
      chk("rr_skip_ch3", int'(if1.out_ch), 3);
      chk("rr_skip_data", int'(if1.out_data), 4'hD);
      tick();
      neg();
      chk("rr_wrap_ch1", int'(if1.out_ch), 1);
      tick();
      sel = 2'd3; in_valid = 4'hF;
      neg();
      chk("oob_sel_ready", int'(if2.in_ready), 0);
      tick();
      neg();
      chk("oob_sel_valid", int'(if2.out_valid), 0);
      for (int i = 0; i < 400; i++) begin
         tick();
         en = ($urandom_range(0, 3) != 0);
         sel = 2'($urandom_range(0, 3));
         in_valid = 4'($urandom_range(0, 15));
         in_data = 16'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 60) == 0);
      end
      tick();
      rst = 1'b0;
`ifdef STREAM_MUX_STATS_EN
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b1; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
      repeat (70000) tick();
      neg();
      chk("stat_sat_ch0", int'(st0[15:0]), 16'hFFFF);
      chk("stat_ch1", int'(st0[31:16]), 0);
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
